// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// Module   : md_sched
// Purpose  : Multiply/divide scheduler for the pipelined MIPS core. Starts
//            mult/multu/div/divu from the E stage, holds them busy for a
//            fixed cycle count, owns HI/LO, serves mfhi/mflo/mthi/mtlo and
//            raises a D-stage stall while an operation is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        IntReq,
  output logic        md_stall,
  output logic        busy,
  output logic        start,
  output logic [31:0] MDout,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [5:0] C_FN_MFHI = 6'h10;
  localparam logic [5:0] C_FN_MTHI = 6'h11;
  localparam logic [5:0] C_FN_MFLO = 6'h12;
  localparam logic [5:0] C_FN_MTLO = 6'h13;
  localparam logic [3:0] C_MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] C_DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Encoding matches the low two funct bits of 0x18..0x1B.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  op_t         op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Register-field bits of the instruction words play no part here.
  logic unused_ir;
  assign unused_ir = ^{IR_D[25:6], IR_E[25:6]};

  // Instruction decode (SPECIAL opcode only).
  logic w_e_special, w_d_special;
  logic w_e_start_op, w_e_mfhi, w_e_mflo, w_e_mthi, w_e_mtlo, w_d_md_op;

  assign w_e_special  = (IR_E[31:26] == 6'd0);
  assign w_d_special  = (IR_D[31:26] == 6'd0);
  assign w_e_start_op = w_e_special && (IR_E[5:2] == 4'b0110);
  assign w_e_mfhi     = w_e_special && (IR_E[5:0] == C_FN_MFHI);
  assign w_e_mflo     = w_e_special && (IR_E[5:0] == C_FN_MFLO);
  assign w_e_mthi     = w_e_special && (IR_E[5:0] == C_FN_MTHI);
  assign w_e_mtlo     = w_e_special && (IR_E[5:0] == C_FN_MTLO);
  assign w_d_md_op    = w_d_special &&
                        ((IR_D[5:2] == 4'b0110) || (IR_D[5:2] == 4'b0100));

  // Outputs derived from state and the current E/D instructions.
  assign busy  = (state_q == S_BUSY);
  assign start = (state_q == S_IDLE) && w_e_start_op && !IntReq;
  // The stall drops in the final busy cycle: the result is written on that
  // edge, so an md-op leaving D then sees the new HI/LO once it reaches E.
  assign md_stall = (start || (busy && (cnt_q != 4'd0))) && w_d_md_op;
  assign MDout = w_e_mfhi ? hi_q : (w_e_mflo ? lo_q : 32'd0);
  assign HI = hi_q;
  assign LO = lo_q;

  // Multiply datapath: 64-bit product of sign- or zero-extended operands.
  logic        w_mul_signed;
  logic [63:0] w_mul_a, w_mul_b, w_prod;

  assign w_mul_signed = (op_q == OP_MULT);
  assign w_mul_a = {(w_mul_signed ? {32{a_q[31]}} : 32'd0), a_q};
  assign w_mul_b = {(w_mul_signed ? {32{b_q[31]}} : 32'd0), b_q};
  assign w_prod  = w_mul_a * w_mul_b;

  // Divide datapath: magnitude divide then sign fix-up. Working on unsigned
  // magnitudes makes 0x80000000 / -1 come out as 0x80000000 rem 0 naturally.
  logic        w_div_signed, w_a_neg, w_b_neg, w_div_zero;
  logic [31:0] w_a_mag, w_b_mag, w_divisor, w_q_mag, w_r_mag, w_quot, w_rem;

  assign w_div_signed = (op_q == OP_DIV);
  assign w_a_neg   = w_div_signed && a_q[31];
  assign w_b_neg   = w_div_signed && b_q[31];
  assign w_a_mag   = w_a_neg ? (32'd0 - a_q) : a_q;
  assign w_b_mag   = w_b_neg ? (32'd0 - b_q) : b_q;
  assign w_div_zero = (b_q == 32'd0);
  assign w_divisor = w_div_zero ? 32'd1 : w_b_mag;
  assign w_q_mag   = w_a_mag / w_divisor;
  assign w_r_mag   = w_a_mag % w_divisor;
  assign w_quot    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem     = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  logic        w_is_div, w_wr_result;
  logic [31:0] w_res_hi, w_res_lo;

  assign w_is_div    = op_q[1];
  assign w_res_hi    = w_is_div ? w_rem  : w_prod[63:32];
  assign w_res_lo    = w_is_div ? w_quot : w_prod[31:0];
  assign w_wr_result = busy && (cnt_q == 4'd0) && !(w_is_div && w_div_zero);

  // Next-state: moves, start latch, countdown and completion write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (w_e_mthi && !IntReq) hi_d = A;
    if (w_e_mtlo && !IntReq) lo_d = A;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BUSY;
          op_d    = op_t'(IR_E[1:0]);
          a_d     = A;
          b_d     = B;
          cnt_d   = IR_E[1] ? C_DIV_LOAD : C_MULT_LOAD;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          // Completion overrides any stray move targeting HI/LO.
          if (w_wr_result) begin
            hi_d = w_res_hi;
            lo_d = w_res_lo;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= OP_MULT;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sched
// Purpose  : Self-checking bench for md_sched: vector table, directed
//            multi-cycle sequences and random traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_sched;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] ADDU  = 32'h0000_0021;
  localparam logic [31:0] MFHI  = 32'h0000_0010;
  localparam logic [31:0] MTHI  = 32'h0000_0011;
  localparam logic [31:0] MFLO  = 32'h0000_0012;
  localparam logic [31:0] MTLO  = 32'h0000_0013;
  localparam logic [31:0] MULT  = 32'h0000_0018;
  localparam logic [31:0] MULTU = 32'h0000_0019;
  localparam logic [31:0] DIV   = 32'h0000_001A;
  localparam logic [31:0] DIVU  = 32'h0000_001B;
  localparam logic [31:0] LW18  = 32'h8C00_0018;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] IR_D, IR_E, A, B;
  logic        IntReq;
  logic        md_stall, busy, start;
  logic [31:0] MDout, HI, LO;

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .IR_D(IR_D), .IR_E(IR_E), .A(A), .B(B),
    .IntReq(IntReq), .md_stall(md_stall), .busy(busy), .start(start),
    .MDout(MDout), .HI(HI), .LO(LO)
  );

  int checks = 0;
  int failures = 0;
  bit en = 1'b0;

  // Reference model: architectural HI/LO, remaining busy cycles, pending result.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  bit          p_valid = 1'b0;
  int          m_left = 0;

  function automatic bit fn_is(input logic [31:0] ir, input logic [5:0] fn);
    return (ir[31:26] == 6'd0) && (ir[5:0] == fn);
  endfunction

  function automatic bit is_start_op(input logic [31:0] ir);
    return fn_is(ir, 6'h18) || fn_is(ir, 6'h19) || fn_is(ir, 6'h1A) || fn_is(ir, 6'h1B);
  endfunction

  function automatic bit is_md_op(input logic [31:0] ir);
    return is_start_op(ir) || fn_is(ir, 6'h10) || fn_is(ir, 6'h11) ||
           fn_is(ir, 6'h12) || fn_is(ir, 6'h13);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_start();
    return (m_left == 0) && is_start_op(IR_E) && !IntReq;
  endfunction

  task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] a,
                       input logic [31:0] b, input logic irq, input logic rst);
    logic [31:0] x_md;
    @(negedge clk);
    IR_D = d; IR_E = e; A = a; B = b; IntReq = irq; reset = rst;
    #1;
    if (en) begin
      x_md = fn_is(IR_E, 6'h10) ? m_hi : (fn_is(IR_E, 6'h12) ? m_lo : 32'd0);
      chk("start",    {31'd0, start},    {31'd0, m_start()});
      chk("busy",     {31'd0, busy},     {31'd0, (m_left > 0)});
      chk("md_stall", {31'd0, md_stall},
          {31'd0, ((m_start() || m_left > 1) && is_md_op(IR_D))});
      chk("MDout", MDout, x_md);
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
    end
  endtask

  // Apply this cycle's inputs to the model as of the coming rising edge.
  task automatic advance();
    bit st, done;
    longint sa, sb, sp, sq, sr;
    longint unsigned up;
    st = m_start();
    done = 1'b0;
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    end else begin
      if (m_left > 0) begin
        m_left--;
        done = (m_left == 0);
      end
      if (!IntReq && fn_is(IR_E, 6'h11)) m_hi = A;
      if (!IntReq && fn_is(IR_E, 6'h13)) m_lo = A;
      if (done && p_valid) begin
        m_hi = p_hi; m_lo = p_lo;
      end
      if (st) begin
        sa = longint'($signed(A));
        sb = longint'($signed(B));
        p_valid = 1'b1;
        if (fn_is(IR_E, 6'h18)) begin
          sp = sa * sb; p_hi = sp[63:32]; p_lo = sp[31:0]; m_left = MC;
        end else if (fn_is(IR_E, 6'h19)) begin
          up = {32'd0, A} * {32'd0, B}; p_hi = up[63:32]; p_lo = up[31:0]; m_left = MC;
        end else if (fn_is(IR_E, 6'h1A)) begin
          m_left = DC;
          if (B == 32'd0) p_valid = 1'b0;
          else begin
            sq = sa / sb; sr = sa % sb; p_lo = sq[31:0]; p_hi = sr[31:0];
          end
        end else begin
          m_left = DC;
          if (B == 32'd0) p_valid = 1'b0;
          else begin
            p_lo = A / B; p_hi = A % B;
          end
        end
      end
    end
  endtask

  task automatic cyc(input logic [31:0] d, input logic [31:0] e, input logic [31:0] a,
                     input logic [31:0] b, input logic irq, input logic rst);
    drive(d, e, a, b, irq, rst);
    advance();
  endtask

  typedef struct {
    logic [31:0] d, e, a, b;
    logic        irq;
    logic        x_start, x_stall, x_busy;
    logic [31:0] x_md, x_hi, x_lo;
  } vec_t;

  vec_t tv[9];

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_ir();
    case ($urandom_range(0, 10))
      0: return NOP;   1: return ADDU;  2: return MFHI;  3: return MTHI;
      4: return MFLO;  5: return MTLO;  6: return MULT;  7: return MULTU;
      8: return DIV;   9: return DIVU;  default: return LW18;
    endcase
  endfunction

  initial begin
    int nb;
    // mult -3*7 with mflo held in D behind it, then read back.
    tv[0] = '{MFLO, MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0};
    tv[1] = '{MFLO, NOP,  32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0};
    tv[2] = '{ADDU, NOP,  32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0};
    tv[3] = '{MFLO, NOP,  32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0};
    tv[4] = '{MFLO, NOP,  32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0};
    tv[5] = '{MFLO, NOP,  32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0};
    tv[6] = '{NOP,  MFLO, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFEB,
              32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tv[7] = '{NOP,  MFHI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tv[8] = '{MULT, MULTU, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,
              32'hFFFF_FFFF, 32'hFFFF_FFEB};

    IR_D = NOP; IR_E = NOP; A = 32'd0; B = 32'd0; IntReq = 1'b0; reset = 1'b1;
    cyc(NOP, NOP, 0, 0, 0, 1);
    cyc(NOP, NOP, 0, 0, 0, 1);
    en = 1'b1;

    // Reset state.
    drive(MFLO, NOP, 0, 0, 0, 0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_mdout", MDout, 32'd0);
    advance();

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      drive(tv[i].d, tv[i].e, tv[i].a, tv[i].b, tv[i].irq, 1'b0);
      chk($sformatf("tv%0d_start", i), {31'd0, start},    {31'd0, tv[i].x_start});
      chk($sformatf("tv%0d_stall", i), {31'd0, md_stall}, {31'd0, tv[i].x_stall});
      chk($sformatf("tv%0d_busy", i),  {31'd0, busy},     {31'd0, tv[i].x_busy});
      chk($sformatf("tv%0d_mdout", i), MDout, tv[i].x_md);
      chk($sformatf("tv%0d_hi", i), HI, tv[i].x_hi);
      chk($sformatf("tv%0d_lo", i), LO, tv[i].x_lo);
      advance();
    end

    // divu 100/7; a div offered in the expiring cycle is refused, next accepted.
    cyc(NOP, DIVU, 32'd100, 32'd7, 0, 0);
    nb = 0;
    for (int i = 1; i <= 9; i++) begin
      cyc(NOP, NOP, 0, 0, 0, 0);
      if (busy) nb++;
    end
    drive(NOP, DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    chk("expire_no_start", {31'd0, start}, 32'd0);
    if (busy) nb++;
    chk("divu_busy_cycles", nb, DC);
    advance();
    drive(NOP, DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);
    chk("div_start", {31'd0, start}, 32'd1);
    advance();
    for (int i = 0; i < DC; i++) cyc(NOP, NOP, 0, 0, 0, 0);
    drive(NOP, NOP, 0, 0, 0, 0);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    advance();

    // Overflow divide.
    cyc(NOP, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    for (int i = 0; i < DC; i++) cyc(NOP, NOP, 0, 0, 0, 0);
    drive(NOP, NOP, 0, 0, 0, 0);
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'd0);
    advance();

    // Start op and mthi killed by IntReq.
    drive(NOP, DIV, 32'd9, 32'd2, 1, 0);
    chk("irq_start", {31'd0, start}, 32'd0);
    advance();
    drive(NOP, MTHI, 32'h1234, 0, 1, 0);
    chk("irq_busy", {31'd0, busy}, 32'd0);
    advance();
    drive(NOP, NOP, 0, 0, 0, 0);
    chk("irq_mthi_hi", HI, 32'd0);
    advance();

    // Divide by zero keeps preloaded HI/LO.
    cyc(NOP, MTHI, 32'hA, 0, 0, 0);
    cyc(NOP, MTLO, 32'hB, 0, 0, 0);
    cyc(NOP, DIV, 32'd5, 32'd0, 0, 0);
    nb = 0;
    for (int i = 0; i < DC + 1; i++) begin
      cyc(NOP, NOP, 0, 0, 0, 0);
      if (busy) nb++;
    end
    chk("dz_busy_cycles", nb, DC);
    drive(NOP, NOP, 0, 0, 0, 0);
    chk("dz_hi", HI, 32'hA);
    chk("dz_lo", LO, 32'hB);
    advance();

    // Reset on the third busy cycle of mult aborts it.
    cyc(NOP, MULT, 32'd3, 32'd4, 0, 0);
    cyc(NOP, NOP, 0, 0, 0, 0);
    cyc(NOP, NOP, 0, 0, 0, 0);
    cyc(NOP, NOP, 0, 0, 0, 1);
    drive(NOP, NOP, 0, 0, 0, 0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", HI, 32'd0);
    chk("rstmid_lo", LO, 32'd0);
    advance();
    for (int i = 0; i < 8; i++) cyc(NOP, NOP, 0, 0, 0, 0);
    drive(NOP, NOP, 0, 0, 0, 0);
    chk("rstmid_late_lo", LO, 32'd0);
    advance();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(pick_ir(), pick_ir(), pick_operand(), pick_operand(),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
